systolic_iobuf_n: RTL and testbench
===================================

SYSTOLIC_IOBUF_N -- requirements
Module: systolic_iobuf_n

Interface
REQ-001 SHALL provide parameter N, default 4, array dimension (N x N PEs), legal 2..8.
REQ-002 SHALL provide parameter DW, default 16, data word width, legal 8..16.
REQ-003 SHALL provide parameter AW, default 8, buffer address width (depth 2**AW words per buffer), legal 4..8.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 ren  in  1  bus read strobe; ibus_radr  in  16  read address.
REQ-008 ibus_rdata  out  16  read data, valid 2 cycles after ren, zero-extended from DW.
REQ-009 wen  in  1  bus write strobe; ibus_wadr  in  16  write address; ibus_wdata  in  16  write data (low DW bits used).
REQ-010 a_in  out  N*DW  row operand words, channel k at bits [k*DW +: DW]; a_we  out  N  per-row valid.
REQ-011 b_in  out  N*DW  column operand words; b_we  out  N  per-column valid.
REQ-012 s_out  in  N*N*DW  PE results, PE p=row*N+col; s_we  in  N*N  per-PE result strobe.
REQ-013 busy  out  1  run in progress; irq  out  1  level interrupt.

Function
REQ-014 Address map: [15:14]=00 A buffer, 01 B buffer, 10 S buffer; [13:8] channel (A/B: 0..N-1, S: 0..N*N-1); [AW-1:0] word; addresses 0xFFF0..0xFFF3 are control; everything else unmapped.
REQ-015 Control: 0xFFF0 write = start; 0xFFF1 LEN (AW+1 bits, 0..2**AW); 0xFFF2 STATUS {overrun[3], timeout[2], done[1], busy[0]}, write-1-to-clear bits 3:1; 0xFFF3 IRQ_EN bit0.
REQ-016 Reads SHALL be 2-cycle pipelined (address decode and RAM read registered, data registered); unmapped, out-of-range channel, or no-ren reads return 0.
REQ-017 Read and write to the same buffer word in one cycle SHALL return the old data.
REQ-018 FSM states IDLE, FEED, DRAIN, DONE; busy=1 in FEED and DRAIN.
REQ-019 IDLE: start write with LEN>0 -> FEED next cycle, feed counter and all S write pointers cleared; LEN=0 -> DONE next cycle.
REQ-020 FEED: for start written at cycle t, a_in[k]/b_in[k] word j SHALL be driven with a_we[k]/b_we[k]=1 at cycle t+1+k+j, j=0..LEN-1 (built-in k-cycle skew); outputs 0 when we=0.
REQ-021 FEED lasts exactly LEN+N-1 cycles, then -> DRAIN.
REQ-022 Any cycle: s_we[p]=1 while busy writes s_out word p into S buffer p at pointer p, pointer increments, wraps modulo 2**AW; s_we while IDLE ignored.
REQ-023 DRAIN -> DONE when every PE has written LEN results; or after 4*N+LEN cycles in DRAIN -> DONE with timeout set.
REQ-024 DONE lasts one cycle, sets done, -> IDLE.
REQ-025 irq = IRQ_EN & done, combinational from registered bits.
REQ-026 Start write while busy SHALL be ignored and set overrun; bus writes to A/B buffers while busy SHALL be dropped and set overrun; S buffer writes from bus always ignored.
REQ-027 Status set and W1C in the same cycle: set wins.
REQ-028 LEN and IRQ_EN writes while busy take effect but LEN is sampled only at start.

Reset
REQ-029 rst SHALL force IDLE, busy=0, irq=0, a_we=b_we=0, a_in=b_in=0, ibus_rdata=0, STATUS=0, LEN=0, IRQ_EN=0, S pointers=0; buffer contents undefined.
REQ-030 rst asserted mid-run SHALL abort immediately; next cycle obeys REQ-029.

Verification
REQ-031 N=4: write A0[0..2]=1,2,3, LEN=3, start at t -> a_we[0] high t+1..t+3 with 1,2,3; a_we[3] high t+4..t+6; busy falls after all 16 PEs pulse s_we 3 times.
REQ-032 Write 0xABCD to B1 word 5, ren same address at t -> ibus_rdata=0x00..CD-masked-to-DW (0xABCD at DW=16) at t+2, 0 at t+3.
REQ-033 Start during run -> no restart, STATUS bit3=1; write 0x8 to 0xFFF2 -> bit3=0.
REQ-034 LEN=2, no s_we -> DRAIN times out after 18 cycles (N=4), STATUS=0x6, irq=1 with IRQ_EN=1.
REQ-035 LEN=0 start -> busy never asserts, done=1 two cycles later, no a_we/b_we.
REQ-036 rst pulse during FEED -> all we low next cycle, STATUS=0, subsequent start runs normally.

Source files
------------

// File: rtl/systolic_iobuf_n_if.sv
// Bus, operand-feed and result-capture signals between the systolic I/O buffer and its neighbours.
interface systolic_iobuf_n_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 16
);
  logic              ren;
  logic [15:0]       ibus_radr;
  logic [15:0]       ibus_rdata;
  logic              wen;
  logic [15:0]       ibus_wadr;
  logic [15:0]       ibus_wdata;
  logic [N*DW-1:0]   a_in;
  logic [N-1:0]      a_we;
  logic [N*DW-1:0]   b_in;
  logic [N-1:0]      b_we;
  logic [N*N*DW-1:0] s_out;
  logic [N*N-1:0]    s_we;
  logic              busy;
  logic              irq;

  modport master (
    output ren, ibus_radr, wen, ibus_wadr, ibus_wdata, s_out, s_we,
    input  ibus_rdata, a_in, a_we, b_in, b_we, busy, irq
  );

  modport slave (
    input  ren, ibus_radr, wen, ibus_wadr, ibus_wdata, s_out, s_we,
    output ibus_rdata, a_in, a_we, b_in, b_we, busy, irq
  );
endinterface

// File: rtl/systolic_iobuf_n.sv
// Operand/result buffers for an N x N systolic array: bus-loaded A/B channels fed out
// with a per-channel skew, PE results captured into S buffers, and a small run controller.
module systolic_iobuf_n #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 8
) (
  input logic               clk,
  input logic               rst,
  systolic_iobuf_n_if.slave bus
);
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned CW    = AW + 2;
  localparam int unsigned NP    = N * N;
  localparam int unsigned AIW   = $clog2(N);
  localparam int unsigned SIW   = $clog2(NP);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  logic [DW-1:0] a_mem [N][DEPTH];
  logic [DW-1:0] b_mem [N][DEPTH];
  logic [DW-1:0] s_mem [NP][DEPTH];

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, dcnt_q, dcnt_d;
  logic [LW-1:0]   len_q, len_d, len_run_q, len_run_d;
  logic [AW-1:0]   ptr_q [NP];
  logic [AW-1:0]   ptr_d [NP];
  logic [LW-1:0]   res_q [NP];
  logic [LW-1:0]   res_d [NP];
  logic            busy_q, busy_d, done_q, done_d, tmo_q, tmo_d, ovr_q, ovr_d;
  logic            irq_en_q, irq_en_d;
  logic [N*DW-1:0] a_in_q, a_in_d, b_in_q, b_in_d;
  logic [N-1:0]    a_we_q, a_we_d, b_we_q, b_we_d;
  logic [15:0]     rd1_q, rd1_d, rdata_q, rdata_d;

  logic            clr_ptr, tmo_set, done_set, ovr_set, all_done;
  logic [2:0]      stat_clr;

  // Bus address decode
  logic [1:0]    w_sel, r_sel;
  logic [5:0]    w_ch, r_ch;
  logic [AW-1:0] w_word, r_word;
  logic          w_lo_ok, r_lo_ok, r_ctl;
  logic          w_ab_hit, ab_wr_ok, start_w, len_w, stat_w, irqen_w;
  logic          unused_wdata;

  assign w_sel    = bus.ibus_wadr[15:14];
  assign w_ch     = bus.ibus_wadr[13:8];
  assign w_word   = bus.ibus_wadr[AW-1:0];
  assign w_lo_ok  = (bus.ibus_wadr[7:0] >> AW) == 8'd0;
  assign r_sel    = bus.ibus_radr[15:14];
  assign r_ch     = bus.ibus_radr[13:8];
  assign r_word   = bus.ibus_radr[AW-1:0];
  assign r_lo_ok  = (bus.ibus_radr[7:0] >> AW) == 8'd0;
  assign r_ctl    = bus.ibus_radr[15:2] == 14'h3FFC;

  assign w_ab_hit = bus.wen && w_lo_ok && !w_sel[1] && ({1'b0, w_ch} < 7'(N));
  assign ab_wr_ok = w_ab_hit && !busy_q;
  assign start_w  = bus.wen && (bus.ibus_wadr == 16'hFFF0);
  assign len_w    = bus.wen && (bus.ibus_wadr == 16'hFFF1);
  assign stat_w   = bus.wen && (bus.ibus_wadr == 16'hFFF2);
  assign irqen_w  = bus.wen && (bus.ibus_wadr == 16'hFFF3);
  assign unused_wdata = ^bus.ibus_wdata;

  // Buffer storage; contents are not reset
  always_ff @(posedge clk) begin
    if (ab_wr_ok && !w_sel[0]) a_mem[w_ch[AIW-1:0]][w_word] <= bus.ibus_wdata[DW-1:0];
    if (ab_wr_ok &&  w_sel[0]) b_mem[w_ch[AIW-1:0]][w_word] <= bus.ibus_wdata[DW-1:0];
    for (int p = 0; p < NP; p++) begin
      if (busy_q && bus.s_we[p]) s_mem[p][ptr_q[p]] <= bus.s_out[p*DW +: DW];
    end
  end

  always_comb begin
    all_done = 1'b1;
    for (int p = 0; p < NP; p++) begin
      if (res_q[p] < len_run_q) all_done = 1'b0;
    end
  end

  // Run controller
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dcnt_d    = dcnt_q;
    len_run_d = len_run_q;
    clr_ptr   = 1'b0;
    tmo_set   = 1'b0;
    done_set  = 1'b0;
    ovr_set   = w_ab_hit && busy_q;
    case (state_q)
      S_IDLE: begin
        if (start_w) begin
          len_run_d = len_q;
          if (len_q != '0) begin
            state_d = S_FEED;
            cnt_d   = '0;
            clr_ptr = 1'b1;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FEED: begin
        ovr_set = ovr_set | start_w;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(len_run_q) + CW'(N - 2)) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end
      end
      S_DRAIN: begin
        ovr_set = ovr_set | start_w;
        dcnt_d  = dcnt_q + CW'(1);
        if (all_done) begin
          state_d = S_DONE;
        end else if (dcnt_q == CW'(len_run_q) + CW'(4 * N - 1)) begin
          state_d = S_DONE;
          tmo_set = 1'b1;
        end
      end
      S_DONE: begin
        done_set = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Result write pointers and per-PE result counts
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      ptr_d[p] = clr_ptr ? '0 : ptr_q[p];
      res_d[p] = clr_ptr ? '0 : res_q[p];
      if (busy_q && bus.s_we[p]) begin
        ptr_d[p] = ptr_q[p] + AW'(1);
        if (res_q[p] != '1) res_d[p] = res_q[p] + LW'(1);
      end
    end
  end

  // Skewed operand feed, computed one cycle ahead so the outputs are flops
  always_comb begin
    a_we_d = '0;
    b_we_d = '0;
    a_in_d = '0;
    b_in_d = '0;
    for (int k = 0; k < N; k++) begin
      if ((state_d == S_FEED) && (cnt_d >= CW'(k)) && ((cnt_d - CW'(k)) < CW'(len_run_d))) begin
        a_we_d[k]          = 1'b1;
        b_we_d[k]          = 1'b1;
        a_in_d[k*DW +: DW] = a_mem[k][AW'(cnt_d - CW'(k))];
        b_in_d[k*DW +: DW] = b_mem[k][AW'(cnt_d - CW'(k))];
      end
    end
  end

  // Control/status registers; a set in the same cycle as a clear wins
  always_comb begin
    stat_clr = stat_w ? bus.ibus_wdata[3:1] : 3'b000;
    ovr_d    = (ovr_q  & ~stat_clr[2]) | ovr_set;
    tmo_d    = (tmo_q  & ~stat_clr[1]) | tmo_set;
    done_d   = (done_q & ~stat_clr[0]) | done_set;
    irq_en_d = irqen_w ? bus.ibus_wdata[0] : irq_en_q;
    len_d    = len_q;
    if (len_w) len_d = (bus.ibus_wdata > 16'(DEPTH)) ? LW'(DEPTH) : bus.ibus_wdata[AW:0];
    busy_d   = (state_d == S_FEED) || (state_d == S_DRAIN);
  end

  // Two-stage bus read: decode+array read, then output register
  always_comb begin
    rd1_d   = '0;
    rdata_d = rd1_q;
    if (bus.ren) begin
      if (r_ctl) begin
        case (bus.ibus_radr[1:0])
          2'd1:    rd1_d = 16'(len_q);
          2'd2:    rd1_d = {12'd0, ovr_q, tmo_q, done_q, busy_q};
          2'd3:    rd1_d = {15'd0, irq_en_q};
          default: rd1_d = '0;
        endcase
      end else if (r_lo_ok) begin
        case (r_sel)
          2'b00:   if ({1'b0, r_ch} < 7'(N))  rd1_d = 16'(a_mem[r_ch[AIW-1:0]][r_word]);
          2'b01:   if ({1'b0, r_ch} < 7'(N))  rd1_d = 16'(b_mem[r_ch[AIW-1:0]][r_word]);
          2'b10:   if ({1'b0, r_ch} < 7'(NP)) rd1_d = 16'(s_mem[r_ch[SIW-1:0]][r_word]);
          default: rd1_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dcnt_q    <= '0;
      len_q     <= '0;
      len_run_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      ovr_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      a_in_q    <= '0;
      b_in_q    <= '0;
      a_we_q    <= '0;
      b_we_q    <= '0;
      rd1_q     <= '0;
      rdata_q   <= '0;
      for (int p = 0; p < NP; p++) begin
        ptr_q[p] <= '0;
        res_q[p] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dcnt_q    <= dcnt_d;
      len_q     <= len_d;
      len_run_q <= len_run_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      ovr_q     <= ovr_d;
      irq_en_q  <= irq_en_d;
      a_in_q    <= a_in_d;
      b_in_q    <= b_in_d;
      a_we_q    <= a_we_d;
      b_we_q    <= b_we_d;
      rd1_q     <= rd1_d;
      rdata_q   <= rdata_d;
      for (int p = 0; p < NP; p++) begin
        ptr_q[p] <= ptr_d[p];
        res_q[p] <= res_d[p];
      end
    end
  end

  assign bus.ibus_rdata = rdata_q;
  assign bus.a_in       = a_in_q;
  assign bus.a_we       = a_we_q;
  assign bus.b_in       = b_in_q;
  assign bus.b_we       = b_we_q;
  assign bus.busy       = busy_q;
  assign bus.irq        = irq_en_q & done_q;
endmodule

// File: tb/tb_systolic_iobuf_n.sv
// Directed bench for systolic_iobuf_n (N=4, DW=16, AW=8): bus access, skewed feed,
// drain completion/timeout, overrun, LEN=0 and mid-run reset.
module tb_systolic_iobuf_n;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  systolic_iobuf_n_if #(.N(N), .DW(DW)) bif ();

  systolic_iobuf_n #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bif.wen        = 1'b1;
    bif.ibus_wadr  = a;
    bif.ibus_wdata = d;
    step();
    bif.wen = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    bif.ren       = 1'b1;
    bif.ibus_radr = a;
    step();
    bif.ren = 1'b0;
    step();
    d = bif.ibus_rdata;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (bif.busy && n < max_cycles) begin
      step();
      n++;
    end
    chk("wait_idle_busy", bif.busy === 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [3:0]  exp_we;
    logic [15:0] exp0, exp3;

    rst            = 1'b1;
    bif.ren        = 1'b0;
    bif.wen        = 1'b0;
    bif.ibus_radr  = 16'h0;
    bif.ibus_wadr  = 16'h0;
    bif.ibus_wdata = 16'h0;
    bif.s_out      = '0;
    bif.s_we       = '0;
    step();
    step();

    // Reset state
    chk("rst_busy",  bif.busy === 1'b0);
    chk("rst_irq",   bif.irq === 1'b0);
    chk("rst_a_we",  bif.a_we === 4'h0);
    chk("rst_b_we",  bif.b_we === 4'h0);
    chk("rst_a_in",  bif.a_in === 64'h0);
    chk("rst_b_in",  bif.b_in === 64'h0);
    chk("rst_rdata", bif.ibus_rdata === 16'h0);
    rst = 1'b0;
    step();
    rd(16'hFFF2, d);
    chk("rst_status", d === 16'h0000);

    // Buffer write and 2-cycle read
    wr(16'h0000, 16'h0001);
    wr(16'h4105, 16'hABCD);
    bif.ren       = 1'b1;
    bif.ibus_radr = 16'h4105;
    step();
    bif.ren = 1'b0;
    step();
    chk("rd_b1w5_t2", bif.ibus_rdata === 16'hABCD);
    step();
    chk("rd_b1w5_t3", bif.ibus_rdata === 16'h0000);

    // Same-cycle read/write returns the old word
    bif.wen        = 1'b1;
    bif.ibus_wadr  = 16'h4105;
    bif.ibus_wdata = 16'h1111;
    bif.ren        = 1'b1;
    bif.ibus_radr  = 16'h4105;
    step();
    bif.wen = 1'b0;
    bif.ren = 1'b0;
    step();
    chk("rd_collide_old", bif.ibus_rdata === 16'hABCD);
    rd(16'h4105, d);
    chk("rd_collide_new", d === 16'h1111);
    rd(16'h0400, d);
    chk("rd_bad_channel", d === 16'h0000);
    rd(16'hC000, d);
    chk("rd_unmapped", d === 16'h0000);
    rd(16'h0000, d);
    chk("rd_a0w0", d === 16'h0001);

    // Full run: LEN=3, skewed feed, all PEs return 3 results
    wr(16'h0001, 16'h0002);
    wr(16'h0002, 16'h0003);
    wr(16'h0300, 16'h0031);
    wr(16'h0301, 16'h0032);
    wr(16'h0302, 16'h0033);
    wr(16'hFFF1, 16'h0003);
    wr(16'hFFF3, 16'h0001);
    wr(16'hFFF0, 16'h0000);
    for (int c = 1; c <= 8; c++) begin
      exp_we = 4'h0;
      for (int k = 0; k < 4; k++) begin
        if (c - 1 - k >= 0 && c - 1 - k <= 2) exp_we[k] = 1'b1;
      end
      exp0 = exp_we[0] ? 16'(c) : 16'h0;
      exp3 = exp_we[3] ? 16'(16'h30 + c - 3) : 16'h0;
      chk("feed_a_we", bif.a_we === exp_we);
      chk("feed_b_we", bif.b_we === exp_we);
      chk("feed_a_in0", bif.a_in[15:0] === exp0);
      chk("feed_a_in3", bif.a_in[63:48] === exp3);
      chk("feed_busy", bif.busy === 1'b1);
      for (int p = 0; p < 16; p++) bif.s_out[p*16 +: 16] = 16'(p * 256 + c);
      bif.s_we = (c >= 5 && c <= 7) ? 16'hFFFF : 16'h0000;
      step();
    end
    chk("run_busy_fall", bif.busy === 1'b0);
    chk("run_irq_early", bif.irq === 1'b0);
    step();
    chk("run_irq", bif.irq === 1'b1);
    rd(16'hFFF2, d);
    chk("run_status", d === 16'h0002);
    rd(16'h8501, d);
    chk("rd_s5w1", d === 16'h0506);
    rd(16'h8F02, d);
    chk("rd_s15w2", d === 16'h0F07);
    wr(16'h8501, 16'hDEAD);
    rd(16'h8501, d);
    chk("s_bus_write_ignored", d === 16'h0506);
    wr(16'hFFF2, 16'h0002);
    chk("irq_cleared", bif.irq === 1'b0);

    // Start and A write while busy: ignored, overrun set
    wr(16'hFFF0, 16'h0000);
    wr(16'hFFF0, 16'h0000);
    wr(16'h0000, 16'h7777);
    chk("ovr_a_we0", bif.a_we[0] === 1'b1);
    chk("ovr_a_in0", bif.a_in[15:0] === 16'h0003);
    wait_idle(100);
    step();
    rd(16'hFFF2, d);
    chk("ovr_status", d === 16'h000E);
    wr(16'hFFF2, 16'h0008);
    rd(16'hFFF2, d);
    chk("ovr_w1c", d === 16'h0006);
    wr(16'hFFF2, 16'h0006);
    rd(16'hFFF2, d);
    chk("ovr_cleared", d === 16'h0000);
    rd(16'h0000, d);
    chk("ovr_a_write_dropped", d === 16'h0001);

    // Drain timeout: LEN=2, no results, 18 DRAIN cycles
    wr(16'hFFF1, 16'h0002);
    wr(16'hFFF0, 16'h0000);
    repeat (22) step();
    chk("tmo_busy_last", bif.busy === 1'b1);
    step();
    chk("tmo_busy_fall", bif.busy === 1'b0);
    chk("tmo_irq_early", bif.irq === 1'b0);
    step();
    chk("tmo_irq", bif.irq === 1'b1);
    rd(16'hFFF2, d);
    chk("tmo_status", d === 16'h0006);
    wr(16'hFFF2, 16'h000E);

    // LEN=0: straight to DONE; W1C in the DONE cycle loses to the set
    wr(16'hFFF1, 16'h0000);
    wr(16'hFFF0, 16'h0000);
    chk("len0_busy", bif.busy === 1'b0);
    chk("len0_a_we", bif.a_we === 4'h0);
    chk("len0_b_we", bif.b_we === 4'h0);
    chk("len0_irq_early", bif.irq === 1'b0);
    wr(16'hFFF2, 16'h0002);
    chk("len0_set_wins", bif.irq === 1'b1);
    chk("len0_busy2", bif.busy === 1'b0);
    rd(16'hFFF2, d);
    chk("len0_status", d === 16'h0002);
    wr(16'hFFF2, 16'h0002);

    // Reset during FEED, then a normal run
    wr(16'hFFF1, 16'h0003);
    wr(16'hFFF0, 16'h0000);
    step();
    chk("pre_rst_a_we", bif.a_we === 4'b0011);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_a_we", bif.a_we === 4'h0);
    chk("mid_rst_b_we", bif.b_we === 4'h0);
    chk("mid_rst_busy", bif.busy === 1'b0);
    chk("mid_rst_a_in", bif.a_in === 64'h0);
    rd(16'hFFF2, d);
    chk("mid_rst_status", d === 16'h0000);
    rd(16'hFFF1, d);
    chk("mid_rst_len", d === 16'h0000);
    rd(16'hFFF3, d);
    chk("mid_rst_irq_en", d === 16'h0000);
    wr(16'hFFF1, 16'h0001);
    wr(16'hFFF0, 16'h0000);
    chk("post_rst_a_we", bif.a_we === 4'b0001);
    chk("post_rst_a_in0", bif.a_in[15:0] === 16'h0001);
    bif.s_we = 16'hFFFF;
    step();
    bif.s_we = 16'h0000;
    chk("post_rst_a_we2", bif.a_we === 4'b0010);
    wait_idle(50);
    step();
    rd(16'hFFF2, d);
    chk("post_rst_status", d === 16'h0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
